// File: rtl/bus_cycle_arbiter.sv
// Two-port round-robin arbiter driving 8086-style T1..T4 bus cycles.
// Inserts wait states on READY low and aborts on wait timeout.
module bus_cycle_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 8,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [1:0]            REQ,
    input  logic [1:0]            REQ_WR,
    input  logic [1:0]            REQ_IOM,
    input  logic [2*ADDR_W-1:0]   REQ_ADDR,
    input  logic [2*DATA_W-1:0]   REQ_WDATA,
    output logic [1:0]            GNT,
    output logic [1:0]            DONE,
    output logic                  ERR,
    output logic [DATA_W-1:0]     RDATA,
    output logic                  ALE,
    output logic [ADDR_W-1:0]     ADDR,
    output logic                  IOM,
    output logic                  RD_N,
    output logic                  WR_N,
    output logic [DATA_W-1:0]     DATA_OUT,
    output logic                  DATA_OE,
    input  logic [DATA_W-1:0]     DATA_IN,
    input  logic                  READY
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4
    } state_t;

    localparam logic [7:0] WT = 8'(WAIT_TIMEOUT);

    state_t              state_q, state_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic                last_q, last_d;
    logic                sel_q, sel_d;
    logic                wr_q, wr_d;
    logic                iom_q, iom_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                to_q, to_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                pick;
    logic                strobe;
    logic [1:0]          sel_oh;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            iom_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            to_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            iom_q   <= iom_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        iom_d   = iom_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        to_d    = to_q;
        rdata_d = rdata_q;
        // On a tie the port not served last wins
        pick    = (REQ == 2'b11) ? ~last_q : REQ[1];
        unique case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    sel_d   = pick;
                    wr_d    = REQ_WR[pick];
                    iom_d   = REQ_IOM[pick];
                    addr_d  = pick ? REQ_ADDR[2*ADDR_W-1:ADDR_W]
                                   : REQ_ADDR[ADDR_W-1:0];
                    wdata_d = pick ? REQ_WDATA[2*DATA_W-1:DATA_W]
                                   : REQ_WDATA[DATA_W-1:0];
                    to_d    = 1'b0;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                wcnt_d  = '0;
                state_d = S_T2;
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (READY) begin
                    if (!wr_q) rdata_d = DATA_IN;
                    state_d = S_T4;
                end else begin
                    state_d = S_TW;
                end
            end
            S_TW: begin
                wcnt_d = wcnt_q + 8'd1;
                if (READY) begin
                    if (!wr_q) rdata_d = DATA_IN;
                    state_d = S_T4;
                end else if (wcnt_q + 8'd1 == WT) begin
                    if (!wr_q) rdata_d = '1;
                    to_d    = 1'b1;
                    state_d = S_T4;
                end
            end
            S_T4: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign strobe   = (state_q == S_T2) || (state_q == S_T3)
                   || (state_q == S_TW);
    assign sel_oh   = sel_q ? 2'b10 : 2'b01;
    assign GNT      = (state_q != S_IDLE) ? sel_oh : 2'b00;
    assign DONE     = (state_q == S_T4) ? sel_oh : 2'b00;
    assign ERR      = (state_q == S_T4) && to_q;
    assign RDATA    = rdata_q;
    assign ALE      = (state_q == S_T1);
    assign ADDR     = addr_q;
    assign IOM      = iom_q;
    assign RD_N     = !(strobe && !wr_q);
    assign WR_N     = !(strobe && wr_q);
    assign DATA_OE  = strobe && wr_q;
    assign DATA_OUT = DATA_OE ? wdata_q : '0;

endmodule

// File: doc/bus_cycle_arbiter.md
Name: bus_cycle_arbiter

Overview:
- Shares one 8086-style memory/IO bus between two requesters: port 0 (CPU) and port 1 (DMA).
- Runs a T1–T4 bus cycle for each granted request: ALE, address, IOM, active-low RD_N/WR_N strobes, and data direction.
- Inserts wait states while the slave holds READY low, and aborts with an error once WAIT_TIMEOUT is exceeded.
- Sits between the requesters and the memory/IO slave model.

Parameters:
- ADDR_W, 20, bus address width
- DATA_W, 8, bus data width
- WAIT_TIMEOUT, 15, maximum TW cycles before abort; legal range 1..255

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- REQ  in  2  per-port request level; held until that port's DONE
- REQ_WR  in  2  per port: 1 = write, 0 = read
- REQ_IOM  in  2  per port: 1 = IO space, 0 = memory space
- REQ_ADDR  in  2*ADDR_W  per-port address; port p uses bits [p*ADDR_W +: ADDR_W]
- REQ_WDATA  in  2*DATA_W  per-port write data
- GNT  out  2  one-hot grant, high from T1 through T4
- DONE  out  2  one-cycle completion pulse on the granted port, asserted in T4
- ERR  out  1  high with DONE when the cycle timed out
- RDATA  out  DATA_W  read data, valid while DONE is high
- ALE  out  1  address latch enable, high in T1 only
- ADDR  out  ADDR_W  bus address, stable T1..T4
- IOM  out  1  bus space select, stable T1..T4
- RD_N  out  1  read strobe, active-low
- WR_N  out  1  write strobe, active-low
- DATA_OUT  out  DATA_W  write data
- DATA_OE  out  1  write data drive enable
- DATA_IN  in  DATA_W  read data from the slave
- READY  in  1  slave ready; 0 inserts a wait state

Behaviour:
- States: IDLE, T1, T2, T3, TW, T4. The wait counter WCNT is 8 bits.
- Reset: async on RESET_N=0. Values while in reset:
  - state = IDLE, WCNT = 0, last-grant pointer = 1, so port 0 wins the first tie.
  - GNT = 0, DONE = 0, ERR = 0, RDATA = 0, ALE = 0, ADDR = 0, IOM = 0.
  - RD_N = 1, WR_N = 1, DATA_OUT = 0, DATA_OE = 0.
- Reset mid-cycle abandons the cycle: no DONE, strobes released immediately.
- IDLE: sample REQ on the rising edge.
  - One request: grant that port.
  - Both requesting: grant the port not granted last (round-robin).
  - Go to T1 and capture WR, IOM, ADDR and WDATA of the winner.
  - No request: stay in IDLE.
- T1: ALE = 1. ADDR/IOM driven from the captured request. GNT set. WCNT cleared. Next state T2.
- T2: read asserts RD_N = 0. Write asserts WR_N = 0, DATA_OE = 1, DATA_OUT = captured data. Next state T3.
- T3: strobes held.
  - READY = 1: go to T4; for a read, capture RDATA = DATA_IN at this edge.
  - READY = 0: go to TW.
- TW: strobes held; WCNT increments each TW cycle.
  - READY = 1: go to T4 and capture read data.
  - Else if WCNT + 1 == WAIT_TIMEOUT: go to T4 with the timeout flag set.
  - Timeout read: RDATA = all ones.
- T4: RD_N/WR_N = 1 and DATA_OE = 0; ADDR/IOM/GNT still held. DONE[granted] = 1, and ERR = timeout flag. Next state IDLE, with the pointer updated to the granted port.
- Latency:
  - REQ first seen in IDLE at cycle 0 gives T1 at cycle 1 and DONE at cycle 4 with zero waits; each TW adds 1.
  - Minimum spacing between back-to-back cycles is 5 clocks (one IDLE cycle between them).
- A requester dropping REQ after grant is ignored; the cycle completes and DONE still pulses.
- New requests arriving during T1..T4 are queued by level only; they are arbitrated in the next IDLE.
- RD_N and WR_N are never low simultaneously. ALE is never high outside T1.

Test Plan:
- Port 0 reads memory 20'h01234, READY = 1, DATA_IN = 8'hA5 → ALE in cycle 1; RD_N low cycles 2–3; DONE[0] and RDATA = 8'hA5 in cycle 4; IOM = 0; ERR = 0.
- Port 1 writes IO 20'h00060 with data 8'h3C, READY low for 3 cycles → three TW cycles; WR_N low cycles 2–6; DATA_OE = 1 with DATA_OUT = 8'h3C; DONE[1] at cycle 7.
- REQ = 2'b11 held continuously → GNT alternates 01, 10, 01, 10; each grant spans 4 cycles, with one IDLE between grants.
- READY held 0, WAIT_TIMEOUT = 15 on a read → exactly 15 TW cycles, then T4 with DONE, ERR = 1 and RDATA = 8'hFF; the next cycle has ERR = 0.
- RESET_N pulsed low during TW of a write → immediately WR_N = 1, DATA_OE = 0, GNT = 0, no DONE; after release, a fresh request gives port 0 priority.
- REQ[0] dropped in T2 → cycle still completes and DONE[0] pulses; the arbiter returns to IDLE and issues no further grant.
